// File: rtl/lab7_soc_pio_poller.sv
// Avalon-MM read master that periodically samples a button PIO, debounces the
// sampled bits and produces per-bit edge pulses plus a sticky interrupt.
module lab7_soc_pio_poller #(
    parameter int WIDTH        = 2,
    parameter int POLL_CYCLES  = 1000,
    parameter int READ_LATENCY = 1,
    parameter int DEB_SAMPLES  = 4,
    parameter int PIO_ADDR     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic             avm_waitrequest,
    input  logic [31:0]      avm_readdata,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             irq,
    input  logic             irq_ack
);

    localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int CW = $clog2(DEB_SAMPLES + 1);

    localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_CYCLES - 1);
    localparam logic [LW-1:0] LAT_RELOAD   = LW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] DEB_MAX      = CW'(DEB_SAMPLES);
    localparam logic [1:0]    ADDR         = 2'(PIO_ADDR);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [LW-1:0]     lat_q, lat_d;

    logic              vld_p0;
    logic [WIDTH-1:0]  sample_p0;

    logic [WIDTH-1:0]  cand_p1, cand_d;
    logic [CW-1:0]     count_p1, count_d;
    logic [WIDTH-1:0]  stable_p1, stable_d;

    logic [WIDTH-1:0]  stable_prev_p2;
    logic [WIDTH-1:0]  rise_p2, fall_p2;
    logic              irq_q;

    logic              unused_readdata;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        if (c >= DEB_MAX) begin
            return DEB_MAX;
        end
        return c + 1'b1;
    endfunction

    assign avm_address     = ADDR;
    assign avm_read        = (state_q == REQ);
    assign sample_p0       = avm_readdata[WIDTH-1:0];
    assign unused_readdata = ^avm_readdata[31:WIDTH];

    // Poll sequencer: interval timer, request handshake, fixed-latency capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= TIMER_RELOAD;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        lat_d   = lat_q;
        vld_p0  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (timer_q == '0) begin
                        state_d = REQ;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            REQ: begin
                if (!avm_waitrequest) begin
                    state_d = WAIT;
                    lat_d   = LAT_RELOAD;
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    vld_p0  = 1'b1;
                    state_d = IDLE;
                    timer_d = TIMER_RELOAD;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stage 1: debounce on each captured sample
    always_comb begin
        cand_d   = cand_p1;
        count_d  = count_p1;
        stable_d = stable_p1;
        if (vld_p0) begin
            if (sample_p0 == cand_p1) begin
                count_d = sat_inc(count_p1);
                if (count_d == DEB_MAX) begin
                    stable_d = sample_p0;
                end
            end else begin
                cand_d  = sample_p0;
                count_d = CW'(1);
                if (DEB_MAX == CW'(1)) begin
                    stable_d = sample_p0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_p1   <= '0;
            count_p1  <= '0;
            stable_p1 <= '0;
        end else begin
            cand_p1   <= cand_d;
            count_p1  <= count_d;
            stable_p1 <= stable_d;
        end
    end

    // Stage 2: edge pulses follow the stable change by one cycle; irq follows rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_prev_p2 <= '0;
            rise_p2        <= '0;
            fall_p2        <= '0;
            irq_q          <= 1'b0;
        end else begin
            stable_prev_p2 <= stable_p1;
            rise_p2        <= stable_p1 & ~stable_prev_p2;
            fall_p2        <= ~stable_p1 & stable_prev_p2;
            irq_q          <= (|rise_p2) | (irq_q & ~irq_ack);
        end
    end

    assign stable = stable_p1;
    assign rise   = rise_p2;
    assign fall   = fall_p2;
    assign irq    = irq_q;

endmodule

// File: tb/tb_lab7_soc_pio_poller.sv
// Randomized self-checking bench for lab7_soc_pio_poller; debounce expectations
// come from a sample-history model (latest run of DEB identical samples).
module tb_lab7_soc_pio_poller;

    localparam int P    = 8;
    localparam int RL   = 1;
    localparam int DEB  = 4;
    localparam int W    = 2;
    localparam int ADDR = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [1:0]   avm_address;
    logic         avm_read;
    logic         avm_waitrequest;
    logic [31:0]  avm_readdata;
    logic [W-1:0] stable, rise, fall;
    logic         irq;
    logic         irq_ack;

    int n_checks = 0;
    int n_pass   = 0;
    int since_idle = 0;
    int cyc = 0;
    int last_req = 0;
    int rise_seen = 0;

    logic         irq_model = 1'b0;
    logic [W-1:0] cur_rise = '0, cur_fall = '0, nxt_rise = '0, nxt_fall = '0;
    logic [W-1:0] hist[$];

    lab7_soc_pio_poller #(
        .WIDTH(W), .POLL_CYCLES(P), .READ_LATENCY(RL), .DEB_SAMPLES(DEB), .PIO_ADDR(ADDR)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .stable(stable), .rise(rise), .fall(fall),
        .irq(irq), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    // Stable value = last sample that closed a run of DEB identical samples.
    function automatic logic [W-1:0] model_stable();
        logic [W-1:0] r = '0;
        bit run;
        for (int i = DEB - 1; i < hist.size(); i++) begin
            run = 1'b1;
            for (int k = 1; k < DEB; k++) if (hist[i-k] != hist[i]) run = 1'b0;
            if (run) r = hist[i];
        end
        return r;
    endfunction

    task automatic step();
        irq_model = (|cur_rise) | (irq_model & ~irq_ack);
        @(posedge clk); #1;
        since_idle++;
        cyc++;
        cur_rise = nxt_rise;
        cur_fall = nxt_fall;
        nxt_rise = '0;
        nxt_fall = '0;
    endtask

    task automatic wait_req(input bit check_gap, input string tag, output bit ok);
        int cnt = 0;
        while (avm_read !== 1'b1 && cnt < 200) begin
            avm_readdata = $urandom;
            step();
            cnt++;
        end
        n_checks++;
        if (avm_read !== 1'b1) begin
            $display("FAIL %s req_timeout: avm_read=%b after %0d cycles, want 1", tag, avm_read, cnt);
            ok = 1'b0;
            return;
        end
        n_pass++;
        ok = 1'b1;
        last_req = cyc;
        if (check_gap) begin
            n_checks++;
            if (since_idle !== P)
                $display("FAIL %s req_gap: got %0d idle cycles, want %0d", tag, since_idle, P);
            else n_pass++;
        end
    endtask

    task automatic do_read(input logic [W-1:0] s, input int stalls, input bit check_gap,
                           input bit drop_en, input bit ack_rise, input string tag);
        bit ok;
        logic [W-1:0] old_st, new_st;
        irq_ack = 1'b0;
        avm_waitrequest = (stalls > 0);
        wait_req(check_gap, tag, ok);
        if (!ok) return;
        old_st = model_stable();
        n_checks++;
        if (stable !== old_st) $display("FAIL %s stable_before: got %b want %b", tag, stable, old_st);
        else n_pass++;
        for (int k = 0; k <= stalls; k++) begin
            n_checks++;
            if (avm_read !== 1'b1 || avm_address !== 2'(ADDR))
                $display("FAIL %s req_hold[%0d]: read=%b addr=%0d want read=1 addr=%0d",
                         tag, k, avm_read, avm_address, ADDR);
            else n_pass++;
            avm_waitrequest = (k < stalls);
            avm_readdata = $urandom;
            step();
        end
        avm_waitrequest = 1'b0;
        if (drop_en) enable = 1'b0;
        for (int k = 0; k < RL; k++) begin
            n_checks++;
            if (avm_read !== 1'b0) $display("FAIL %s wait_read: got %b want 0", tag, avm_read);
            else n_pass++;
            avm_readdata = (k == RL - 1) ? {30'($urandom), s} : $urandom;
            step();
        end
        since_idle = 0;
        avm_readdata = $urandom;
        hist.push_back(s);
        new_st = model_stable();
        n_checks++;
        if (stable !== new_st) $display("FAIL %s stable_after: got %b want %b", tag, stable, new_st);
        else n_pass++;
        n_checks++;
        if (rise !== '0 || fall !== '0)
            $display("FAIL %s edge_early: rise=%b fall=%b want 00/00", tag, rise, fall);
        else n_pass++;
        nxt_rise = new_st & ~old_st;
        nxt_fall = old_st & ~new_st;
        step();
        n_checks++;
        if (rise !== cur_rise || fall !== cur_fall)
            $display("FAIL %s edge_pulse: rise=%b fall=%b want %b/%b", tag, rise, fall, cur_rise, cur_fall);
        else n_pass++;
        if (rise !== '0) rise_seen++;
        irq_ack = ack_rise;
        step();
        irq_ack = 1'b0;
        n_checks++;
        if (irq !== irq_model) $display("FAIL %s irq: got %b want %b", tag, irq, irq_model);
        else n_pass++;
        n_checks++;
        if (rise !== '0 || fall !== '0)
            $display("FAIL %s edge_late: rise=%b fall=%b want 00/00", tag, rise, fall);
        else n_pass++;
    endtask

    task automatic ack_irq(input string tag);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL %s irq_clear: got %b want 0", tag, irq);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if (avm_read !== 1'b0 || avm_address !== 2'(ADDR))
            $display("FAIL reset_bus: read=%b addr=%0d want 0/%0d", avm_read, avm_address, ADDR);
        else n_pass++;
        n_checks++;
        if (stable !== '0 || rise !== '0 || fall !== '0 || irq !== 1'b0)
            $display("FAIL reset_out: stable=%b rise=%b fall=%b irq=%b want all 0", stable, rise, fall, irq);
        else n_pass++;
    endtask

    task automatic test_basic();
        int prev;
        for (int i = 0; i < 4; i++) begin
            prev = last_req;
            do_read(2'b01, 0, 1'b1, 1'b0, 1'b0, "basic");
            if (i > 0) begin
                n_checks++;
                if (last_req - prev !== P + RL + 1)
                    $display("FAIL basic_spacing: got %0d want %0d", last_req - prev, P + RL + 1);
                else n_pass++;
            end
        end
        n_checks++;
        if (stable !== 2'b01 || irq !== 1'b1)
            $display("FAIL basic_final: stable=%b irq=%b want 01/1", stable, irq);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        wait_req(1'b0, "rst_mid", ok);
        if (!ok) return;
        avm_waitrequest = 1'b0;
        avm_readdata = $urandom;
        step();
        reset = 1'b1;
        #1;
        n_checks++;
        if (avm_read !== 1'b0 || stable !== '0 || irq !== 1'b0)
            $display("FAIL rst_mid_async: read=%b stable=%b irq=%b want 0/00/0", avm_read, stable, irq);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        hist.delete();
        irq_model = 1'b0;
        cur_rise = '0; cur_fall = '0; nxt_rise = '0; nxt_fall = '0;
        since_idle = 0;
        do_read(2'b01, 0, 1'b1, 1'b0, 1'b0, "rst_first");
    endtask

    task automatic test_bounce();
        logic [W-1:0] seq[6] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
        int r0 = rise_seen;
        for (int i = 0; i < 6; i++) begin
            do_read(seq[i], 0, 1'b1, 1'b0, 1'b0, "bounce");
            if (i == 4) begin
                n_checks++;
                if (stable !== 2'b00) $display("FAIL bounce_hold: got %b want 00", stable);
                else n_pass++;
            end
        end
        n_checks++;
        if (stable !== 2'b01 || rise_seen - r0 !== 1)
            $display("FAIL bounce_final: stable=%b rises=%0d want 01/1", stable, rise_seen - r0);
        else n_pass++;
    endtask

    task automatic test_stall();
        do_read(2'b10, 3, 1'b1, 1'b0, 1'b0, "stall3");
        do_read(2'b10, 1, 1'b1, 1'b0, 1'b0, "stall1");
    endtask

    task automatic test_fall_irq();
        ack_irq("fall_pre_ack");
        for (int i = 0; i < 4; i++) do_read(2'b11, 0, 1'b1, 1'b0, 1'b0, "to_11");
        n_checks++;
        if (stable !== 2'b11 || irq !== 1'b1)
            $display("FAIL to_11_final: stable=%b irq=%b want 11/1", stable, irq);
        else n_pass++;
        ack_irq("fall_ack");
        for (int i = 0; i < 4; i++) do_read(2'b00, 0, 1'b1, 1'b0, 1'b0, "to_00");
        n_checks++;
        if (stable !== 2'b00 || irq !== 1'b0)
            $display("FAIL to_00_final: stable=%b irq=%b want 00/0", stable, irq);
        else n_pass++;
        for (int i = 0; i < 4; i++) do_read(2'b01, 0, 1'b1, 1'b0, 1'b1, "ack_rise");
        n_checks++;
        if (irq !== 1'b1) $display("FAIL ack_rise_final: irq=%b want 1", irq);
        else n_pass++;
    endtask

    task automatic test_enable();
        int bad = 0;
        for (int i = 0; i < 3; i++) do_read(2'b10, 0, 1'b1, 1'b0, 1'b0, "en_pre");
        do_read(2'b10, 0, 1'b1, 1'b1, 1'b0, "en_drop");
        n_checks++;
        if (stable !== 2'b10) $display("FAIL en_drop_sample: stable=%b want 10", stable);
        else n_pass++;
        repeat (30) begin
            if (avm_read !== 1'b0) bad++;
            avm_readdata = $urandom;
            step();
        end
        n_checks++;
        if (bad !== 0) $display("FAIL en_idle: %0d cycles with avm_read, want 0", bad);
        else n_pass++;
        enable = 1'b1;
        since_idle = 0;
        do_read(2'b10, 0, 1'b1, 1'b0, 1'b0, "en_resume");
    endtask

    task automatic test_random();
        logic [W-1:0] s = 2'b10;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) s = W'($urandom);
            do_read(s, $urandom_range(0, 3), 1'b1, 1'b0, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        avm_waitrequest = 1'b0;
        avm_readdata = '0;
        irq_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        since_idle = 0;
        test_basic();
        test_reset_mid_wait();
        test_bounce();
        test_stall();
        test_fall_irq();
        test_enable();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
